param_or_capture: RTL

PARAM_OR_CAPTURE -- requirements
Module: param_or_capture

---
 rtl/param_or_capture_if.sv | 25 ++
 rtl/param_or_capture.sv | 86 ++++++++
 2 files changed

// File: rtl/param_or_capture_if.sv
// Bundles the channel inputs, control and status outputs of param_or_capture.
// The design side uses the slave modport and the driver side uses master.
interface param_or_capture_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] in_vec;
    logic [WIDTH-1:0] mask;
    logic [1:0]       mode;
    logic             clr;
    logic             out_r;
    logic [WIDTH-1:0] sticky;
    logic             irq;
    logic [CNT_W-1:0] rise_cnt;

    modport slave (
        input  in_vec, mask, mode, clr,
        output out_r, sticky, irq, rise_cnt
    );

    modport master (
        output in_vec, mask, mode, clr,
        input  out_r, sticky, irq, rise_cnt
    );
endinterface

// File: rtl/param_or_capture.sv
// Masked reduction (OR/AND/XOR/NOR) of WIDTH channels with registered output, per-channel
// sticky activity flags, a rise-triggered irq held until clr, and a saturating rise counter.
module param_or_capture #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    param_or_capture_if.slave  bus
);
    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } irq_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    irq_state_t       state;
    irq_state_t       state_next;
    logic [WIDTH-1:0] eff_or;
    logic [WIDTH-1:0] eff_and;
    logic             red;
    logic             rise;
    logic             out_q;
    logic [WIDTH-1:0] sticky_q;
    logic [WIDTH-1:0] sticky_next;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_next;

    // Masked-off channels are forced to the identity value of each reduction.
    assign eff_or  = bus.in_vec & bus.mask;
    assign eff_and = bus.in_vec | ~bus.mask;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        red = 1'b0;
        unique case (bus.mode)
            2'b00:   red = |eff_or;
            2'b01:   red = &eff_and;
            2'b10:   red = ^eff_or;
            default: red = ~|eff_or;
        endcase
    end

    assign rise = red & ~out_q;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (rise) state_next = PEND;
            default: if (bus.clr && !rise) state_next = IDLE;
        endcase
    end

    // A rise on the clearing edge is kept: clr acknowledges only older events.
    always_comb begin
        cnt_next = cnt_q;
        if (bus.clr) begin
            cnt_next = rise ? CNT_W'(1) : '0;
        end else if (rise && cnt_q != CNT_MAX) begin
            cnt_next = cnt_q + CNT_W'(1);
        end
    end

    assign sticky_next = (bus.clr ? '0 : sticky_q) | eff_or;

    // NOTE: state registers use non-blocking assignments so all updates commit together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q    <= 1'b0;
            sticky_q <= '0;
            state    <= IDLE;
            cnt_q    <= '0;
        end else begin
            out_q    <= red;
            sticky_q <= sticky_next;
            state    <= state_next;
            cnt_q    <= cnt_next;
        end
    end

    assign bus.out_r    = out_q;
    assign bus.sticky   = sticky_q;
    assign bus.irq      = (state == PEND);
    assign bus.rise_cnt = cnt_q;
endmodule
